// File: rtl/window_loader.sv
// Write-side loader for the N*N window RAM: streams pixels in over valid/ready,
// then holds the completed window until the read side reports it consumed.
module window_loader #(
  parameter int N       = 8,
  parameter int bitSize = 6,
  parameter int PIXEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               in_ready,
  input  logic               read_done,
  input  logic               flush,
  output logic               mem_we,
  output logic [bitSize:0]   mem_addr,
  output logic [PIXEL_W-1:0] mem_wdata,
  output logic               window_ready,
  output logic [bitSize:0]   fill_count,
  output logic [15:0]        window_count
);

  localparam logic [bitSize:0] LAST_ADDR  = (bitSize+1)'(N*N-1);
  localparam logic [bitSize:0] FULL_COUNT = (bitSize+1)'(N*N);

  typedef enum logic {
    S_FILL,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [bitSize:0]   r_wr_addr;
  logic [bitSize:0]   r_fill_count;
  logic [15:0]        r_window_count;
  logic               r_mem_we;
  logic [bitSize:0]   r_mem_addr;
  logic [PIXEL_W-1:0] r_mem_wdata;
  logic               w_accept;
  logic               w_last;

  assign in_ready     = (r_state == S_FILL);
  assign w_accept     = in_valid & in_ready;
  assign w_last       = w_accept & (r_wr_addr == LAST_ADDR);

  // HOLD is entered on the same edge that registers the final write, so
  // window_ready rises together with mem_we for the last pixel.
  assign window_ready = (r_state == S_HOLD);
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign fill_count   = r_fill_count;
  assign window_count = r_window_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_FILL;
    end else begin
      case (r_state)
        S_FILL:  if (w_last)    w_state_next = S_HOLD;
        S_HOLD:  if (read_done) w_state_next = S_FILL;
        default: w_state_next = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr      <= '0;
      r_fill_count   <= '0;
      r_window_count <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_we <= w_accept & ~flush;
      if (flush) begin
        r_wr_addr    <= '0;
        r_fill_count <= '0;
      end else if (w_accept) begin
        r_mem_addr  <= r_wr_addr;
        r_mem_wdata <= in_pixel;
        if (w_last) begin
          r_wr_addr      <= '0;
          r_fill_count   <= FULL_COUNT;
          r_window_count <= r_window_count + 16'd1;
        end else begin
          r_wr_addr    <= r_wr_addr + 1'b1;
          r_fill_count <= r_fill_count + 1'b1;
        end
      end else if ((r_state == S_HOLD) && read_done) begin
        r_fill_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader: a vector table for short handshake cases,
// followed by hand-written full-window, gapped, flush, hold and reset sequences.
module tb_window_loader;

  localparam int N       = 8;
  localparam int bitSize = 6;
  localparam int PIXEL_W = 8;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [PIXEL_W-1:0] in_pixel;
  logic               in_ready;
  logic               read_done;
  logic               flush;
  logic               mem_we;
  logic [bitSize:0]   mem_addr;
  logic [PIXEL_W-1:0] mem_wdata;
  logic               window_ready;
  logic [bitSize:0]   fill_count;
  logic [15:0]        window_count;

  int n_checks = 0;
  int n_errors = 0;

  window_loader #(.N(N), .bitSize(bitSize), .PIXEL_W(PIXEL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_pixel     (in_pixel),
    .in_ready     (in_ready),
    .read_done    (read_done),
    .flush        (flush),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .window_ready (window_ready),
    .fill_count   (fill_count),
    .window_count (window_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  p;
    logic        rd;
    logic        fl;
    logic        we;
    logic [6:0]  addr;
    logic [7:0]  wd;
    logic        wr;
    logic        rdy;
    logic [6:0]  fc;
    logic [15:0] wc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic rd, input logic fl);
    in_valid  = v;
    in_pixel  = p;
    read_done = rd;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [6:0] addr,
                         input logic [7:0] wd, input logic wr, input logic rdy,
                         input logic [6:0] fc, input logic [15:0] wc);
    chk({tag, ".mem_we"},       32'(mem_we),       32'(we));
    chk({tag, ".mem_addr"},     32'(mem_addr),     32'(addr));
    chk({tag, ".mem_wdata"},    32'(mem_wdata),    32'(wd));
    chk({tag, ".window_ready"}, 32'(window_ready), 32'(wr));
    chk({tag, ".in_ready"},     32'(in_ready),     32'(rdy));
    chk({tag, ".fill_count"},   32'(fill_count),   32'(fc));
    chk({tag, ".window_count"}, 32'(window_count), 32'(wc));
  endtask

  initial begin
    int k;
    //          v     p      rd    fl    we    addr  wd     wr    rdy   fc    wc
    vecs[0] = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 7'd0, 8'hA0, 1'b0, 1'b1, 7'd1, 16'd0};
    vecs[1] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 7'd0, 8'hA0, 1'b0, 1'b1, 7'd1, 16'd0};
    vecs[2] = '{1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 7'd1, 8'hB1, 1'b0, 1'b1, 7'd2, 16'd0};
    vecs[3] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 7'd1, 8'hB1, 1'b0, 1'b1, 7'd0, 16'd0};
    vecs[4] = '{1'b1, 8'hD3, 1'b0, 1'b0, 1'b1, 7'd0, 8'hD3, 1'b0, 1'b1, 7'd1, 16'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 8'hD3, 1'b0, 1'b1, 7'd1, 16'd0};
    vecs[6] = '{1'b1, 8'hE4, 1'b0, 1'b0, 1'b1, 7'd1, 8'hE4, 1'b0, 1'b1, 7'd2, 16'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd1, 8'hE4, 1'b0, 1'b1, 7'd0, 16'd0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd1, 8'hE4, 1'b0, 1'b1, 7'd0, 16'd0};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; read_done = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].p, vecs[i].rd, vecs[i].fl);
      chk_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd,
              vecs[i].wr, vecs[i].rdy, vecs[i].fc, vecs[i].wc);
    end

    // Continuous full window: pixels 0..63 at addresses 0..63
    for (int i = 0; i < N*N; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i < N*N-1)
        chk_all($sformatf("cont%0d", i), 1'b1, 7'(i), 8'(i), 1'b0, 1'b1, 7'(i+1), 16'd0);
      else
        chk_all("cont_last", 1'b1, 7'd63, 8'd63, 1'b1, 1'b0, 7'd64, 16'd1);
    end

    // HOLD with the source still pushing: nothing may be written
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk_all($sformatf("hold%0d", i), 1'b0, 7'd63, 8'd63, 1'b1, 1'b0, 7'd64, 16'd1);
    end
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk_all("read_done", 1'b0, 7'd63, 8'd63, 1'b0, 1'b1, 7'd0, 16'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk_all("post_hold", 1'b1, 7'd0, 8'h55, 1'b0, 1'b1, 7'd1, 16'd1);

    // Flush after 30 accepts with a pixel presented in the flush cycle
    for (int i = 1; i < 30; i++) begin
      step(1'b1, 8'(i + 8'h80), 1'b0, 1'b0);
      chk_all($sformatf("pre_flush%0d", i), 1'b1, 7'(i), 8'(i + 8'h80), 1'b0, 1'b1, 7'(i+1), 16'd1);
    end
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk_all("flush", 1'b0, 7'd29, 8'h9D, 1'b0, 1'b1, 7'd0, 16'd1);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk_all("post_flush", 1'b1, 7'd0, 8'h11, 1'b0, 1'b1, 7'd1, 16'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("flush2", 1'b0, 7'd0, 8'h11, 1'b0, 1'b1, 7'd0, 16'd1);

    // Gapped source: valid on even cycles only, 128 cycles to complete
    k = 0;
    for (int c = 0; c < 2*N*N; c++) begin
      if (c % 2 == 0) begin
        step(1'b1, 8'(k + 8'h40), 1'b0, 1'b0);
        chk($sformatf("gap%0d.mem_we", c),   32'(mem_we),    32'd1);
        chk($sformatf("gap%0d.mem_addr", c), 32'(mem_addr),  32'(k));
        chk($sformatf("gap%0d.wdata", c),    32'(mem_wdata), 32'(8'(k + 8'h40)));
        k++;
      end else begin
        step(1'b0, 8'hFF, 1'b0, 1'b0);
        chk($sformatf("gap%0d.mem_we", c), 32'(mem_we), 32'd0);
      end
      chk($sformatf("gap%0d.window_ready", c), 32'(window_ready), 32'(c >= 2*N*N-2));
      chk($sformatf("gap%0d.fill_count", c), 32'(fill_count), 32'(k));
    end
    chk("gap.window_count", 32'(window_count), 32'd2);

    // Asynchronous reset between clock edges, mid-fill
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("rel", 1'b0, 7'd63, 8'h7F, 1'b0, 1'b1, 7'd0, 16'd2);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(i + 8'h30), 1'b0, 1'b0);
      chk_all($sformatf("prerst%0d", i), 1'b1, 7'(i), 8'(i + 8'h30), 1'b0, 1'b1, 7'(i+1), 16'd2);
    end
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd0, 16'd0);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("after_rst_idle", 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd0, 16'd0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk_all("after_rst_fill", 1'b1, 7'd0, 8'h77, 1'b0, 1'b1, 7'd1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_loader.md
Name: window_loader

Overview:
- Write-side companion to the window address counter: accepts a pixel stream over a valid/ready handshake and writes it into the N*N window memory at addresses 0..N*N-1.
- Raises window_ready once the window is complete, then holds off input until the read side signals read_done.
- Sits between the pixel source and the window RAM; the read-side counter sweeps the same RAM while window_ready is high.

Parameters:
- N, 8, window edge length; the window holds N*N pixels.
- bitSize, 6, address MSB index; address width is bitSize+1 bits; N*N-1 must fit.
- PIXEL_W, 8, pixel data width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  source has a pixel on in_pixel.
- in_pixel  input  PIXEL_W  pixel data.
- in_ready  output  1  loader accepts a pixel this cycle.
- read_done  input  1  single-cycle pulse from the read side: window consumed.
- flush  input  1  synchronous abort of the current fill.
- mem_we  output  1  window RAM write enable (registered).
- mem_addr  output  bitSize+1  window RAM write address (registered).
- mem_wdata  output  PIXEL_W  window RAM write data (registered).
- window_ready  output  1  high while a complete window is held.
- fill_count  output  bitSize+1  pixels written into the current window so far.
- window_count  output  16  completed windows since reset; wraps at 2^16.

Behaviour:
- Reset (async, rst=1): state=FILL, wr_addr=0, fill_count=0, window_count=0, mem_we=0, mem_addr=0, mem_wdata=0, window_ready=0.
- in_ready is combinational from state only: 1 in FILL, 0 in HOLD. It never depends on in_valid.
- Accept = in_valid & in_ready.
- FILL state:
  - On accept: next cycle mem_we=1, mem_addr=wr_addr, mem_wdata=in_pixel.
  - On accept: wr_addr and fill_count increment by 1.
  - Without accept: next cycle mem_we=0; mem_addr and mem_wdata hold their values.
  - Write latency is 1 cycle from accept to mem_we.
- FILL -> HOLD:
  - Trigger: accept while wr_addr == N*N-1.
  - That final write still issues at address N*N-1.
  - Next cycle: window_ready=1, in_ready=0, wr_addr=0, fill_count=N*N, window_count increments.
  - window_ready therefore rises in the same cycle as mem_we for the final pixel.
- HOLD state:
  - mem_we=0 and no input is accepted.
  - On read_done: next cycle state=FILL, window_ready=0, fill_count=0.
  - The first new accept is possible in the cycle after read_done.
- read_done while in FILL is ignored and not stored.
- flush:
  - Takes effect in the next cycle in either state: state=FILL, wr_addr=0, fill_count=0, window_ready=0, mem_we=0.
  - window_count is unchanged.
  - flush has priority over accept and read_done in the same cycle; a pixel presented in that cycle is dropped.
- Simultaneous final accept and flush: flush wins; no HOLD entry and no window_count increment.
- Address never exceeds N*N-1; no wrap occurs while in FILL because the FILL -> HOLD transition resets wr_addr.
- window_count wraps from 65535 to 0 silently.
- Reset mid-fill or mid-hold returns all state to reset values immediately; no partial write is issued after reset deasserts.

Test Plan:
- Reset then continuous in_valid=1 with pixels 0..63 (N=8):
  - Required: mem_we on 64 consecutive cycles, addr 0..63, wdata=addr.
  - Required: window_ready=1 in the cycle of the addr-63 write; in_ready=0 from the next cycle; window_count=1.
- Source gapped (in_valid toggling every cycle):
  - Required: addresses stay contiguous 0..63, mem_we only on cycles following an accept, fill completes after 128 cycles.
- In HOLD, hold in_valid=1 for 20 cycles then pulse read_done:
  - Required: no writes during HOLD; window_ready falls the next cycle; the next accepted pixel goes to addr 0.
- flush after 30 accepts, with in_valid=1 in the same cycle:
  - Required: that pixel is not written; the next write is at addr 0; fill_count=0; window_count unchanged.
- read_done pulsed during FILL at fill_count=10:
  - Required: no effect; fill continues at addr 10.
- Assert rst asynchronously mid-fill, between clock edges:
  - Required: all outputs go to 0 before the next edge; after release the fill restarts at addr 0.
